// File: rtl/max_bus_responder.sv
// ---------------------------------------------------------------------------
// max_bus_responder
//
// CPLD-side responder for the FPGA parallel register bus. The FPGA drives
// max_csn / max_wen / max_oen asynchronously. This block synchronizes them,
// decodes reads and writes into a four-entry register file, and turns CTRL
// writes into a held reconfiguration request toward the configuration
// sequencer.
//
// Ports
//   clkin_max_100  in   1   sole clock
//   sys_reset      in   1   asynchronous active-high reset
//   max_csn        in   1   chip select, active low, asynchronous
//   max_wen        in   1   write strobe, active low, asynchronous
//   max_oen        in   1   read strobe, active low, asynchronous
//   bus_addr       in   2   register address
//   bus_din        in  16   write data
//   bus_dout       out 16   read data
//   bus_doe        out  1   read-data output enable
//   cur_page       in   2   page currently loaded by the sequencer
//   conf_done      in   1   FPGA configuration done (asynchronous)
//   reconfig_req   out  1   level request to reconfigure from page_sel
//   page_sel       out  2   target page, stable while reconfig_req=1
//   reconfig_ack   in   1   single-cycle pulse, consumes the request
//
// Register map
//   0 ID       RO  ID_VALUE
//   1 CTRL     [0] REQ (write-1 launch, reads reconfig_req), [2:1] PAGE
//   2 STATUS   [1:0] cur_page, [2] conf_done, [3] busy, [4] ERR (W1C)
//   3 SCRATCH  RW 16 bits
// ---------------------------------------------------------------------------
module max_bus_responder #(
   parameter logic [15:0] ID_VALUE     = 16'h5A01,
   parameter logic [1:0]  DEFAULT_PAGE = 2'b01
) (
   input  logic        clkin_max_100,
   input  logic        sys_reset,
   input  logic        max_csn,
   input  logic        max_wen,
   input  logic        max_oen,
   input  logic [1:0]  bus_addr,
   input  logic [15:0] bus_din,
   output logic [15:0] bus_dout,
   output logic        bus_doe,
   input  logic [1:0]  cur_page,
   input  logic        conf_done,
   output logic        reconfig_req,
   output logic [1:0]  page_sel,
   input  logic        reconfig_ack
);

   localparam logic [1:0] ADDR_ID      = 2'd0;
   localparam logic [1:0] ADDR_CTRL    = 2'd1;
   localparam logic [1:0] ADDR_STATUS  = 2'd2;
   localparam logic [1:0] ADDR_SCRATCH = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WR_ACT    = 2'd1,
      WR_COMMIT = 2'd2,
      RD_ACT    = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Strobe synchronizers. Bit order {oen, wen, csn}; all flops reset to the
   // inactive (high) level so a reset never looks like an access.
   // ------------------------------------------------------------------------
   logic [2:0] strobe_pin;
   logic [2:0] strobe_sync;
   logic       csn_s;
   logic       wen_s;
   logic       oen_s;

   assign strobe_pin = {max_oen, max_wen, max_csn};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_strobe_sync
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clkin_max_100 or posedge sys_reset) begin
            if (sys_reset) begin
               meta_reg <= 1'b1;
               sync_reg <= 1'b1;
            end else begin
               meta_reg <= strobe_pin[gi];
               sync_reg <= meta_reg;
            end
         end

         assign strobe_sync[gi] = sync_reg;
      end
   endgenerate

   assign csn_s = strobe_sync[0];
   assign wen_s = strobe_sync[1];
   assign oen_s = strobe_sync[2];

   // conf_done synchronizer (reported in STATUS only).
   logic conf_meta_reg;
   logic conf_s_reg;

   always_ff @(posedge clkin_max_100 or posedge sys_reset) begin
      if (sys_reset) begin
         conf_meta_reg <= 1'b0;
         conf_s_reg    <= 1'b0;
      end else begin
         conf_meta_reg <= conf_done;
         conf_s_reg    <= conf_meta_reg;
      end
   end

   // ------------------------------------------------------------------------
   // Access FSM
   // ------------------------------------------------------------------------
   state_t state_reg;
   state_t state_next;
   logic   load_rd;        // entering RD_ACT: capture read data
   logic   commit;         // WR_COMMIT cycle: apply addr_q/data_q

   always_comb begin
      state_next = state_reg;
      load_rd    = 1'b0;
      unique case (state_reg)
         IDLE: begin
            // A write wins even when oen is low at the same time.
            if (!csn_s && !wen_s) begin
               state_next = WR_ACT;
            end else if (!csn_s && !oen_s) begin
               state_next = RD_ACT;
               load_rd    = 1'b1;
            end
         end
         WR_ACT: begin
            if (wen_s || csn_s) begin
               state_next = WR_COMMIT;
            end
         end
         WR_COMMIT: begin
            state_next = IDLE;
         end
         RD_ACT: begin
            // A write strobe during a read aborts the read so the bus
            // is released before the write is taken.
            if (oen_s || csn_s || !wen_s) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign commit = (state_reg == WR_COMMIT);

   always_ff @(posedge clkin_max_100 or posedge sys_reset) begin
      if (sys_reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Write capture: addr/data follow the pins for the whole write strobe so
   // the last sampled value (pins still stable) is what gets committed.
   // ------------------------------------------------------------------------
   logic [1:0]  addr_q_reg;
   logic [15:0] data_q_reg;

   always_ff @(posedge clkin_max_100 or posedge sys_reset) begin
      if (sys_reset) begin
         addr_q_reg <= 2'd0;
         data_q_reg <= 16'd0;
      end else if (state_reg == WR_ACT) begin
         addr_q_reg <= bus_addr;
         data_q_reg <= bus_din;
      end
   end

   // ------------------------------------------------------------------------
   // Register file and request handshake
   // ------------------------------------------------------------------------
   logic        req_reg;
   logic [1:0]  page_reg;
   logic        err_reg;
   logic [15:0] scratch_reg;
   logic [1:0]  wr_page;

   assign wr_page = data_q_reg[2:1];

   always_ff @(posedge clkin_max_100 or posedge sys_reset) begin
      if (sys_reset) begin
         req_reg     <= 1'b0;
         page_reg    <= DEFAULT_PAGE;
         err_reg     <= 1'b0;
         scratch_reg <= 16'd0;
      end else begin
         // An ack only ever clears a pending request; a CTRL commit only
         // ever sets one when none is pending, so the two never collide.
         if (req_reg && reconfig_ack) begin
            req_reg <= 1'b0;
         end
         if (commit) begin
            unique case (addr_q_reg)
               ADDR_CTRL: begin
                  // While busy the whole CTRL write is dropped, even an
                  // invalid page that would otherwise raise ERR.
                  if (!req_reg) begin
                     if (wr_page == 2'b11) begin
                        err_reg <= 1'b1;
                     end else begin
                        page_reg <= wr_page;
                        if (data_q_reg[0]) begin
                           req_reg <= 1'b1;
                        end
                     end
                  end
               end
               ADDR_STATUS: begin
                  if (data_q_reg[4]) begin
                     err_reg <= 1'b0;
                  end
               end
               ADDR_SCRATCH: begin
                  scratch_reg <= data_q_reg;
               end
               default: begin
                  // ID is read-only
               end
            endcase
         end
      end
   end

   assign reconfig_req = req_reg;
   assign page_sel     = page_reg;

   // ------------------------------------------------------------------------
   // Read path: data is captured once on entry to RD_ACT and held.
   // ------------------------------------------------------------------------
   logic [15:0] rd_data;

   always_comb begin
      rd_data = 16'd0;
      unique case (bus_addr)
         ADDR_ID:      rd_data = ID_VALUE;
         ADDR_CTRL:    rd_data = {13'd0, page_reg, req_reg};
         ADDR_STATUS:  rd_data = {11'd0, err_reg, req_reg, conf_s_reg, cur_page};
         ADDR_SCRATCH: rd_data = scratch_reg;
         default:      rd_data = 16'd0;
      endcase
   end

   logic [15:0] dout_reg;
   logic        doe_reg;

   always_ff @(posedge clkin_max_100 or posedge sys_reset) begin
      if (sys_reset) begin
         dout_reg <= 16'd0;
         doe_reg  <= 1'b0;
      end else begin
         doe_reg <= (state_next == RD_ACT);
         if (load_rd) begin
            dout_reg <= rd_data;
         end
      end
   end

   // Gating with wen_s drops the enable in the very cycle a write strobe
   // appears, before the FSM has had an edge to leave RD_ACT.
   assign bus_doe  = doe_reg & wen_s;
   assign bus_dout = dout_reg;

endmodule

// File: tb/tb_max_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_max_bus_responder
//
// Self-checking bench for max_bus_responder. Bus accesses are driven on the
// falling clock edge and outputs are sampled on falling edges. A register-
// level model (page, request, error, scratch) is updated per completed
// access and supplies every expected value.
// ---------------------------------------------------------------------------
module tb_max_bus_responder;

   logic        clk = 1'b0;
   logic        sys_reset;
   logic        max_csn;
   logic        max_wen;
   logic        max_oen;
   logic [1:0]  bus_addr;
   logic [15:0] bus_din;
   logic [15:0] bus_dout;
   logic        bus_doe;
   logic [1:0]  cur_page;
   logic        conf_done;
   logic        reconfig_req;
   logic [1:0]  page_sel;
   logic        reconfig_ack;

   int total = 0;
   int bad   = 0;

   // Register-level model
   logic [1:0]  m_page;
   logic        m_req;
   logic        m_err;
   logic [15:0] m_scratch;

   always #5 clk = ~clk;

   max_bus_responder dut (
      .clkin_max_100 (clk),
      .sys_reset     (sys_reset),
      .max_csn       (max_csn),
      .max_wen       (max_wen),
      .max_oen       (max_oen),
      .bus_addr      (bus_addr),
      .bus_din       (bus_din),
      .bus_dout      (bus_dout),
      .bus_doe       (bus_doe),
      .cur_page      (cur_page),
      .conf_done     (conf_done),
      .reconfig_req  (reconfig_req),
      .page_sel      (page_sel),
      .reconfig_ack  (reconfig_ack)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running need done");
      $fatal(1);
   end

   // ---------------- model ----------------
   task automatic model_reset();
      m_page    = 2'b01;
      m_req     = 1'b0;
      m_err     = 1'b0;
      m_scratch = 16'h0000;
   endtask

   task automatic model_write(input logic [1:0] a, input logic [15:0] d);
      logic [1:0] pg;
      pg = d[2:1];
      case (a)
         2'd1: begin
            if (!m_req) begin
               if (pg == 2'b11) m_err = 1'b1;
               else begin
                  m_page = pg;
                  if (d[0]) m_req = 1'b1;
               end
            end
         end
         2'd2: if (d[4]) m_err = 1'b0;
         2'd3: m_scratch = d;
         default: ;
      endcase
   endtask

   function automatic logic [15:0] exp_read(input logic [1:0] a);
      case (a)
         2'd0:    return 16'h5A01;
         2'd1:    return {13'd0, m_page, m_req};
         2'd2:    return {11'd0, m_err, m_req, conf_done, cur_page};
         default: return m_scratch;
      endcase
   endfunction

   // ---------------- bus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      bus_addr = a;
      bus_din  = d;
      max_csn  = 1'b0;
      max_wen  = 1'b0;
      tick(6);
      max_csn = 1'b1;
      max_wen = 1'b1;
      tick(7);
      model_write(a, d);
      $display("write addr=%0d data=%h", a, d);
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
      logic found;
      found = 1'b0;
      d     = 16'hxxxx;
      @(negedge clk);
      bus_addr = a;
      max_csn  = 1'b0;
      max_oen  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (bus_doe === 1'b1) begin
            found = 1'b1;
            d     = bus_dout;
            break;
         end
      end
      tick(4);
      max_csn = 1'b1;
      max_oen = 1'b1;
      tick(7);
      if (!found) begin
         total++;
         bad++;
         $display("FAIL read_timeout addr=%0d: bus_doe got 0 need 1 within 10 clocks", a);
      end
      $display("read  addr=%0d data=%h", a, d);
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      reconfig_ack = 1'b1;
      tick(1);
      reconfig_ack = 1'b0;
      if (m_req) m_req = 1'b0;
      $display("ack pulse");
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [15:0] rd;
      sys_reset = 1'b1;
      tick(3);
      total++;
      if (bus_doe !== 1'b0 || bus_dout !== 16'h0000 || reconfig_req !== 1'b0 || page_sel !== 2'b01) begin
         bad++;
         $display("FAIL reset_outputs: got doe=%b dout=%h req=%b page=%b need 0 0000 0 01",
                  bus_doe, bus_dout, reconfig_req, page_sel);
      end
      sys_reset = 1'b0;
      model_reset();
      tick(3);
      bus_read(2'd3, rd);
      total++;
      if (rd !== exp_read(2'd3)) begin
         bad++;
         $display("FAIL reset_scratch: got %h need %h", rd, exp_read(2'd3));
      end
      bus_read(2'd2, rd);
      total++;
      if (rd !== exp_read(2'd2)) begin
         bad++;
         $display("FAIL reset_status: got %h need %h", rd, exp_read(2'd2));
      end
   endtask

   task automatic test_read_id();
      @(negedge clk);
      bus_addr = 2'd0;
      max_csn  = 1'b0;
      max_oen  = 1'b0;
      tick(2);
      total++;
      if (bus_doe !== 1'b0) begin
         bad++;
         $display("FAIL rd_doe_early: got %b need 0 at clock 2", bus_doe);
      end
      tick(1);
      total++;
      if (bus_doe !== 1'b1 || bus_dout !== 16'h5A01) begin
         bad++;
         $display("FAIL rd_id: got doe=%b dout=%h need 1 5a01 at clock 3", bus_doe, bus_dout);
      end
      tick(5);
      max_oen = 1'b1;
      max_csn = 1'b1;
      tick(2);
      total++;
      if (bus_doe !== 1'b1) begin
         bad++;
         $display("FAIL rd_doe_hold: got %b need 1 two clocks after release", bus_doe);
      end
      tick(1);
      total++;
      if (bus_doe !== 1'b0) begin
         bad++;
         $display("FAIL rd_doe_fall: got %b need 0 three clocks after release", bus_doe);
      end
      tick(4);
      $display("read  addr=0 timing checked");
   endtask

   task automatic test_launch_reconfig();
      logic [15:0] rd;
      bus_write(2'd1, 16'h0005);
      total++;
      if (page_sel !== 2'b10 || reconfig_req !== 1'b1) begin
         bad++;
         $display("FAIL launch: got page=%b req=%b need 10 1", page_sel, reconfig_req);
      end
      bus_read(2'd2, rd);
      total++;
      if (rd !== exp_read(2'd2) || rd[3] !== 1'b1) begin
         bad++;
         $display("FAIL launch_status: got %h need %h", rd, exp_read(2'd2));
      end
      pulse_ack();
      total++;
      if (reconfig_req !== 1'b0) begin
         bad++;
         $display("FAIL ack_clear: got req=%b need 0 one clock after ack", reconfig_req);
      end
   endtask

   task automatic test_busy_lockout();
      bus_write(2'd1, 16'h0005);
      bus_write(2'd1, 16'h0003);
      total++;
      if (page_sel !== 2'b10 || reconfig_req !== 1'b1) begin
         bad++;
         $display("FAIL busy_lockout: got page=%b req=%b need 10 1", page_sel, reconfig_req);
      end
      pulse_ack();
      tick(6);
      total++;
      if (reconfig_req !== m_req || page_sel !== m_page) begin
         bad++;
         $display("FAIL busy_no_second: got req=%b page=%b need %b %b",
                  reconfig_req, page_sel, m_req, m_page);
      end
   endtask

   task automatic test_ack_collision();
      bus_write(2'd1, 16'h0005);
      @(negedge clk);
      bus_addr = 2'd1;
      bus_din  = 16'h0001;
      max_csn  = 1'b0;
      max_wen  = 1'b0;
      tick(6);
      max_csn = 1'b1;
      max_wen = 1'b1;
      // The commit cycle is the third clock after the strobe rises.
      tick(3);
      reconfig_ack = 1'b1;
      tick(1);
      reconfig_ack = 1'b0;
      m_req = 1'b0;
      tick(5);
      total++;
      if (reconfig_req !== 1'b0 || page_sel !== 2'b10) begin
         bad++;
         $display("FAIL ack_collision: got req=%b page=%b need 0 10", reconfig_req, page_sel);
      end
      $display("write addr=1 data=0001 with simultaneous ack");
   endtask

   task automatic test_invalid_page();
      logic [15:0] rd;
      bus_write(2'd1, 16'h0007);
      bus_read(2'd2, rd);
      total++;
      if (reconfig_req !== 1'b0 || rd[4] !== 1'b1 || rd !== exp_read(2'd2)) begin
         bad++;
         $display("FAIL invalid_page: got req=%b status=%h need 0 %h", reconfig_req, rd, exp_read(2'd2));
      end
      bus_write(2'd2, 16'h0010);
      bus_read(2'd2, rd);
      total++;
      if (rd[4] !== 1'b0 || rd !== exp_read(2'd2)) begin
         bad++;
         $display("FAIL err_clear: got status=%h need %h", rd, exp_read(2'd2));
      end
   endtask

   task automatic test_random();
      logic [15:0] rd;
      logic [15:0] d;
      logic [1:0]  a;
      cur_page  = 2'($urandom_range(0, 3));
      conf_done = 1'($urandom_range(0, 1));
      tick(4);
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0: bus_write(2'd3, 16'($urandom));
            1: bus_write(2'd1, {13'($urandom), 3'($urandom_range(0, 7))});
            2: begin
               a = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2;
               bus_write(a, 16'($urandom));
            end
            default: pulse_ack();
         endcase
         total++;
         if (reconfig_req !== m_req || page_sel !== m_page) begin
            bad++;
            $display("FAIL rand_ctrl[%0d]: got req=%b page=%b need %b %b",
                     i, reconfig_req, page_sel, m_req, m_page);
         end
         a = 2'($urandom_range(0, 3));
         bus_read(a, rd);
         total++;
         if (rd !== exp_read(a)) begin
            bad++;
            $display("FAIL rand_read[%0d] addr=%0d: got %h need %h", i, a, rd, exp_read(a));
         end
      end
   endtask

   task automatic test_contention();
      logic [15:0] rd;
      logic        hist[$];
      logic        seen1;
      logic        seen2;
      logic [15:0] val1;
      logic [15:0] val2;
      int          guarded;
      // Part A: write and read strobes together -> write wins, no drive.
      @(negedge clk);
      bus_addr = 2'd3;
      bus_din  = 16'h1234;
      max_csn  = 1'b0;
      max_wen  = 1'b0;
      max_oen  = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick(1);
         total++;
         if (bus_doe !== 1'b0) begin
            bad++;
            $display("FAIL contention_doe[%0d]: got %b need 0", c, bus_doe);
         end
      end
      max_csn = 1'b1;
      max_wen = 1'b1;
      max_oen = 1'b1;
      tick(7);
      model_write(2'd3, 16'h1234);
      bus_read(2'd3, rd);
      total++;
      if (rd !== exp_read(2'd3)) begin
         bad++;
         $display("FAIL contention_write: got %h need %h", rd, exp_read(2'd3));
      end
      // Part B: read with a write-strobe glitch in the middle.
      seen1   = 1'b0;
      seen2   = 1'b0;
      val1    = 16'h0;
      val2    = 16'h0;
      guarded = 0;
      bus_din = 16'hA5A5;
      for (int c = 0; c < 28; c++) begin
         @(negedge clk);
         // Synchronized wen lags the pin by two clocks.
         if (hist.size() >= 2 && hist[hist.size() - 2] == 1'b0) begin
            guarded++;
            total++;
            if (bus_doe !== 1'b0) begin
               bad++;
               $display("FAIL doe_while_wen[%0d]: got %b need 0", c, bus_doe);
            end
         end
         if (bus_doe === 1'b1 && c < 10 && !seen1) begin
            seen1 = 1'b1;
            val1  = bus_dout;
         end
         if (bus_doe === 1'b1 && c >= 12 && !seen2) begin
            seen2 = 1'b1;
            val2  = bus_dout;
         end
         if (c == 0) begin
            max_csn = 1'b0;
            max_oen = 1'b0;
            max_wen = 1'b1;
         end
         if (c == 6)  max_wen = 1'b0;
         if (c == 9)  max_wen = 1'b1;
         if (c == 20) begin
            max_csn = 1'b1;
            max_oen = 1'b1;
         end
         hist.push_back(max_wen);
      end
      model_write(2'd3, 16'hA5A5);
      total++;
      if (!seen1 || val1 !== 16'h1234) begin
         bad++;
         $display("FAIL glitch_read_before: got seen=%b data=%h need 1 1234", seen1, val1);
      end
      total++;
      if (!seen2 || val2 !== m_scratch) begin
         bad++;
         $display("FAIL glitch_write_commit: got seen=%b data=%h need 1 %h", seen2, val2, m_scratch);
      end
      total++;
      if (guarded < 3) begin
         bad++;
         $display("FAIL glitch_coverage: got %0d guarded clocks need >=3", guarded);
      end
      tick(4);
      $display("contention sequence done");
   endtask

   task automatic test_reset_mid_read();
      logic [15:0] rd;
      logic        found;
      bus_write(2'd3, 16'hBEEF);
      bus_write(2'd1, 16'h0000);
      found = 1'b0;
      @(negedge clk);
      bus_addr = 2'd3;
      max_csn  = 1'b0;
      max_oen  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (bus_doe === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found || bus_dout !== 16'hBEEF) begin
         bad++;
         $display("FAIL pre_reset_read: got doe=%b dout=%h need 1 beef", found, bus_dout);
      end
      sys_reset = 1'b1;
      #1;
      total++;
      if (bus_doe !== 1'b0 || bus_dout !== 16'h0000 || reconfig_req !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: got doe=%b dout=%h req=%b need 0 0000 0",
                  bus_doe, bus_dout, reconfig_req);
      end
      max_csn = 1'b1;
      max_oen = 1'b1;
      tick(3);
      sys_reset = 1'b0;
      model_reset();
      tick(3);
      bus_read(2'd3, rd);
      total++;
      if (rd !== exp_read(2'd3) || page_sel !== 2'b01) begin
         bad++;
         $display("FAIL post_reset: got scratch=%h page=%b need %h 01", rd, page_sel, exp_read(2'd3));
      end
   endtask

   initial begin
      sys_reset    = 1'b1;
      max_csn      = 1'b1;
      max_wen      = 1'b1;
      max_oen      = 1'b1;
      bus_addr     = 2'd0;
      bus_din      = 16'h0;
      cur_page     = 2'b00;
      conf_done    = 1'b0;
      reconfig_ack = 1'b0;
      model_reset();

      test_reset();
      test_read_id();
      test_launch_reconfig();
      test_busy_lockout();
      test_ack_collision();
      test_invalid_page();
      test_random();
      test_contention();
      test_reset_mid_read();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/max_bus_responder.md
# max_bus_responder

Register-access responder for the FPGA-to-CPLD parallel bus: the far side of the max_csn / max_wen / max_oen strobes the FPGA drives.
- Lives in the system CPLD next to the configuration sequencer.
- Decodes FPGA reads and writes into a small register file.
- Turns a FPGA write to CTRL into a held reconfiguration request (with target page) toward the sequencer, and reports sequencer status back on reads.
- Drives read data onto the shared FSM data bus only while a clean read strobe is active.

## Interface
Parameters:
- ID_VALUE, 16'h5A01, constant returned by register 0.
- DEFAULT_PAGE, 2'b01, reset value of the page-select register.

Ports:
- clkin_max_100  in  1  sole clock; every flop is in this domain.
- sys_reset  in  1  asynchronous, active-high reset.
- max_csn  in  1  FPGA chip select, active low, asynchronous to clkin_max_100.
- max_wen  in  1  FPGA write strobe, active low, asynchronous.
- max_oen  in  1  FPGA read strobe, active low, asynchronous.
- bus_addr  in  2  register address; top connects fsm_a[2:1].
- bus_din  in  16  write data sampled from fsm_d.
- bus_dout  out  16  read data toward fsm_d.
- bus_doe  out  1  output enable for fsm_d; top tristates fsm_d when 0.
- cur_page  in  2  page currently loaded by the sequencer (pfl_str).
- conf_done  in  1  fpga_conf_done, passed through a 2-flop synchronizer internally.
- reconfig_req  out  1  level request to the sequencer to reconfigure from page_sel.
- page_sel  out  2  target page, stable whenever reconfig_req=1.
- reconfig_ack  in  1  single-cycle pulse from the sequencer; it consumes the request.

## Operation
Register map:
- 0 ID: RO, returns ID_VALUE.
- 1 CTRL: [0] REQ, write-1 launches a request and reads back reconfig_req; [2:1] PAGE, RW, reads page_sel.
- 2 STATUS: [1:0] cur_page; [2] conf_done (synchronized); [3] busy (= reconfig_req); [4] ERR, sticky, write 1 to clear; other bits read 0.
- 3 SCRATCH: RW, 16 bits.

Synchronization:
- max_csn, max_wen and max_oen each pass through 2 flops, which reset to 1. The synchronized versions are csn_s, wen_s and oen_s.
- bus_addr and bus_din are captured into addr_q and data_q on every cycle in which the FSM is in WR_ACT.

FSM states: IDLE, WR_ACT, WR_COMMIT, RD_ACT.
- IDLE -> WR_ACT when csn_s=0 and wen_s=0. A write takes priority even if oen_s=0 at the same time.
- IDLE -> RD_ACT when csn_s=0, oen_s=0 and wen_s=1. On entry, bus_dout is loaded from the register addressed by bus_addr and bus_doe goes to 1.
- WR_ACT -> WR_COMMIT when wen_s=1 or csn_s=1.
- WR_COMMIT updates the register at addr_q with data_q, then goes to IDLE. This state always lasts exactly 1 cycle.
- RD_ACT -> IDLE when oen_s=1, csn_s=1 or wen_s=0. On exit bus_doe goes to 0. bus_dout holds its value and does not update while in RD_ACT.

Write rules:
- CTRL while busy=1: the entire write is ignored, including PAGE.
- CTRL with REQ=1, PAGE≠2'b11 and busy=0: page_sel<=PAGE and reconfig_req<=1.
- CTRL with PAGE=2'b11: no request and page_sel is unchanged; ERR is set.
- CTRL with REQ=0 and a valid PAGE: only page_sel is updated.
- Writes to ID have no effect. STATUS writes only clear ERR.

Request handshake:
- reconfig_ack=1 clears reconfig_req on the next edge.
- If the ack arrives in the same cycle as a WR_COMMIT to CTRL, the commit sees busy=1 and is dropped; the ack wins.
- An ack while reconfig_req=0 is ignored.

Reset: asserting sys_reset in any state forces the following immediately (asynchronously), including mid-read:
- state IDLE, bus_doe 0, bus_dout 0, reconfig_req 0;
- page_sel DEFAULT_PAGE, SCRATCH 0, ERR 0;
- synchronizer flops 1.

## Timing
- Write: the commit edge comes 3 clocks after max_wen rises at the pin (2 synchronizer stages plus the FSM transition). reconfig_req asserts 1 clock after WR_COMMIT.
- Read: bus_doe rises 3 clocks after max_oen falls (with csn already low). It falls 3 clocks after max_oen or max_csn rises.
- FPGA timing contract: strobe low ≥ 6 clocks (60 ns); address and data stable for the whole strobe plus 3 clocks after it rises; ≥ 4 clocks between accesses.
- bus_doe is never 1 while wen_s=0.

## Test plan
- Read ID: csn=0, oen=0 for 8 clocks, addr=0 -> bus_doe=1 starting on clock 3 with bus_dout=16'h5A01; bus_doe=0 3 clocks after oen rises.
- Launch reconfig: write CTRL=16'h0005 -> page_sel=2'b10 and reconfig_req=1. Reading STATUS then gives busy=1. An ack pulse clears reconfig_req on the next clock.
- Busy lockout: write CTRL=16'h0003 while reconfig_req=1 -> page_sel stays 2'b10, and no second request follows the ack.
- Invalid page: write CTRL=16'h0007 -> reconfig_req stays 0 and STATUS[4]=1. Writing STATUS=16'h0010 then reads STATUS[4]=0.
- Contention: wen and oen driven low together, then oen low alone with a wen glitch mid-read -> bus_doe never 1 while wen_s=0, and the write commits.
- Reset mid-read: assert sys_reset while bus_doe=1 with SCRATCH=16'hBEEF -> bus_doe=0 immediately; after release SCRATCH=0 and page_sel=2'b01.
